// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline interlock unit:
// default widths, stall-vector bit positions and the usual result latencies.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_LAT_W  = 3;

  localparam int STL_PC    = 0;
  localparam int STL_IFID  = 1;
  localparam int STL_IDEX  = 2;
  localparam int STL_EXMEM = 3;
  localparam int STL_MEMWB = 4;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // What the front end is told to do this cycle; flush outranks interlock.
  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_INTERLOCK,
    MODE_FLUSH
  } hz_mode_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage view of the interlock unit: operand/destination info in,
// per-stage hold, bubble, flush and debug status out.
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = 3,
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_en;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wen;
  logic [LAT_W-1:0]          id_lat;
  logic                      br_taken;
  logic [NUM_STAGES-1:0]     stall;
  logic                      nop;
  logic                      flushIF;
  logic                      issue;
  logic                      hz_flag;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_src, id_src_en, id_dst, id_wen, id_lat, br_taken,
    input  stall, nop, flushIF, issue, hz_flag, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_en, id_dst, id_wen, id_lat, br_taken,
    output stall, nop, flushIF, issue, hz_flag, stall_cnt
  );
endinterface

// File: rtl/hz_flush_seq.sv
// Holds the IF flush for FLUSH_CYC cycles after the most recent taken branch;
// a new branch mid-flush restarts the window.
module hz_flush_seq #(
  parameter int FLUSH_CYC = 1
) (
  input  logic clk,
  input  logic Rst,
  input  logic br_taken,
  output logic flushIF
);

  logic [1:0] flush_ctr;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)
      flush_ctr <= '0;
    else if (br_taken)
      flush_ctr <= 2'(FLUSH_CYC - 1);
    else if (flush_ctr != '0)
      flush_ctr <= flush_ctr - 2'd1;
  end

  assign flushIF = br_taken | (flush_ctr != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-result interlock for the in-order five-stage pipeline: a countdown
// per architectural register, front-end stall/bubble, branch flush and a debug stall count.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = DEF_LAT_W,
  parameter int FWD_EN     = 1,
  parameter int WB_LAT     = 3,
  parameter int NUM_STAGES = 5,
  parameter logic [NUM_STAGES-1:0] STALL_MASK =
    NUM_STAGES'((1 << STL_PC) | (1 << STL_IFID) | (1 << STL_IDEX)),
  parameter int FLUSH_CYC  = 1,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                Rst,
  hazard_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0]               load_val;
  logic                           haz;
  logic                           flushing;
  logic                           hz_next;
  logic                           issue;
  hz_mode_e                       mode;

  assign load_val = (FWD_EN != 0) ? bus.id_lat : LAT_W'(WB_LAT);
  assign cnt[0]   = '0;

  // One countdown per register; a fresh issue to the same register wins over the decrement.
  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
      logic [LAT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge Rst) begin
        if (Rst)
          cnt_q <= '0;
        else if (issue && bus.id_wen && (bus.id_dst == REG_AW'(r)))
          cnt_q <= load_val;
        else if (cnt_q != '0)
          cnt_q <= cnt_q - 1'b1;
      end

      assign cnt[r] = cnt_q;
    end
  endgenerate

  // With one cycle left the reader in ID can take the forwarded value as it enters EX.
  always_comb begin
    logic [REG_AW-1:0] src;
    src = '0;
    haz = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = bus.id_src[k*REG_AW +: REG_AW];
      if (bus.id_src_en[k] && (src != '0) && (cnt[src] > LAT_W'(1)))
        haz = 1'b1;
    end
    haz = haz & bus.id_valid;
  end

  hz_flush_seq #(
    .FLUSH_CYC (FLUSH_CYC)
  ) u_flush (
    .clk      (clk),
    .Rst      (Rst),
    .br_taken (bus.br_taken),
    .flushIF  (flushing)
  );

  always_comb begin
    mode = MODE_RUN;
    if (flushing)
      mode = MODE_FLUSH;
    else if (haz)
      mode = MODE_INTERLOCK;
  end

  always_comb begin
    bus.stall   = '0;
    bus.nop     = 1'b0;
    bus.flushIF = 1'b0;
    issue       = 1'b0;
    case (mode)
      MODE_FLUSH: begin
        bus.nop     = 1'b1;
        bus.flushIF = 1'b1;
      end
      MODE_INTERLOCK: begin
        bus.stall = STALL_MASK;
        bus.nop   = 1'b1;
      end
      default: issue = bus.id_valid;
    endcase
  end

  assign bus.issue = issue;
  assign hz_next   = haz & ~flushing;

  // Debug status: last-cycle interlock flag and a stall counter that pins at all-ones.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      bus.hz_flag   <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      bus.hz_flag <= hz_next;
      if (hz_next && (bus.stall_cnt != '1))
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end

endmodule
